// File: rtl/exec_mc.sv
// Multi-cycle tenyr execution unit: rhs = f(X, O) + A.
// Single-cycle ALU ops plus an iterative shift-add multiplier.
module exec_mc #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             swap,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);

    localparam int MUL_CYC = WIDTH / MUL_BITS;
    localparam int CW      = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_addend;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_o;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_f;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_part;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_rsv;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_sh_big;

    assign in_ready  = reset_n && !flush &&
                       (r_state == S_IDLE ||
                        (r_state == S_HOLD && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign w_is_mul  = (op == 4'h3);
    assign out_valid = (r_state == S_HOLD);
    assign busy      = (r_state == S_MUL);
    assign result    = r_result;
    assign err       = r_err;

    assign w_o      = swap ? imm : y;
    assign w_a      = swap ? y : imm;
    assign w_sh_big = (w_o >= WIDTH'(WIDTH));

    always_comb begin
        w_f   = '0;
        w_rsv = 1'b0;
        case (op)
            4'h0: w_f = x | w_o;
            4'h1: w_f = x & w_o;
            4'h2: w_f = x + w_o;
            4'h3: w_f = '0;
            4'h5: w_f = w_sh_big ? '0 : (x << w_o);
            4'h6: w_f = {WIDTH{$signed(x) < $signed(w_o)}};
            4'h7: w_f = {WIDTH{x == w_o}};
            4'h8: w_f = {WIDTH{$signed(x) > $signed(w_o)}};
            4'h9: w_f = x & ~w_o;
            4'hA: w_f = x ^ w_o;
            4'hB: w_f = x - w_o;
            4'hC: w_f = x ^ ~w_o;
            4'hD: w_f = w_sh_big ? '0 : (x >> w_o);
            4'hE: w_f = {WIDTH{x != w_o}};
            default: w_rsv = 1'b1;
        endcase
        w_alu = w_rsv ? '0 : (w_f + w_a);
    end

    // One radix-2^MUL_BITS digit of the multiplier per cycle
    always_comb begin
        w_part = '0;
        for (int b = 0; b < MUL_BITS; b++) begin
            if (r_mplier[b]) begin
                w_part = w_part + (r_mcand << b);
            end
        end
        w_acc_nxt = r_acc + w_part;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_is_mul ? S_MUL : S_HOLD;
                end
            end
            S_MUL: begin
                if (r_cnt == '0) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_accept) begin
                    w_next = w_is_mul ? S_MUL : S_HOLD;
                end else if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (flush) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= '0;
            r_err    <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_addend <= '0;
            r_cnt    <= '0;
        end else if (!flush) begin
            if (w_accept) begin
                if (w_is_mul) begin
                    r_acc    <= '0;
                    r_mcand  <= x;
                    r_mplier <= w_o;
                    r_addend <= w_a;
                    r_cnt    <= CW'(MUL_CYC - 1);
                end else begin
                    r_result <= w_alu;
                    r_err    <= w_rsv;
                end
            end else if (r_state == S_MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << MUL_BITS;
                r_mplier <= r_mplier >> MUL_BITS;
                if (r_cnt == '0) begin
                    r_result <= w_acc_nxt + r_addend;
                    r_err    <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_mc.sv
// Scoreboard bench for exec_mc: directed cases, latency, streaming,
// reserved ops, reset and flush mid-multiply, then random traffic.
module tb_exec_mc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic        swap;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        err;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          g_rnd = 1'b0;
    logic [32:0] exp_q[$];
    int          pop_cyc[$];
    logic [32:0] m_e;

    exec_mc #(.WIDTH(32), .MUL_BITS(1)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .swap     (swap),
        .x        (x),
        .y        (y),
        .imm      (imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tenyr rhs straight from the op table
    function automatic logic [32:0] model(input logic [3:0] o_op,
                                          input logic s,
                                          input logic [31:0] xv,
                                          input logic [31:0] yv,
                                          input logic [31:0] iv);
        logic [31:0] o;
        logic [31:0] a;
        logic [31:0] f;
        logic [63:0] p;
        o = s ? iv : yv;
        a = s ? yv : iv;
        f = 32'h0;
        case (o_op)
            4'h0: f = xv | o;
            4'h1: f = xv & o;
            4'h2: f = xv + o;
            4'h3: begin
                p = {32'h0, xv} * {32'h0, o};
                f = p[31:0];
            end
            4'h5: f = (o >= 32) ? 32'h0 : xv << o;
            4'h6: f = ($signed(xv) < $signed(o)) ? 32'hFFFFFFFF : 32'h0;
            4'h7: f = (xv == o) ? 32'hFFFFFFFF : 32'h0;
            4'h8: f = ($signed(xv) > $signed(o)) ? 32'hFFFFFFFF : 32'h0;
            4'h9: f = xv & ~o;
            4'hA: f = xv ^ o;
            4'hB: f = xv - o;
            4'hC: f = ~(xv ^ o);
            4'hD: f = (o >= 32) ? 32'h0 : xv >> o;
            4'hE: f = (xv != o) ? 32'hFFFFFFFF : 32'h0;
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, f + a};
    endfunction

    // Monitor: every delivered result is matched against the queue head
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none",
                         result);
            end else begin
                m_e = exp_q.pop_front();
                chk("result", {32'h0, result}, {32'h0, m_e[31:0]});
                chk("err", {63'h0, err}, {63'h0, m_e[32]});
            end
            pop_cyc.push_back(cyc);
        end
    end

    // Presents a bundle, waits for acceptance, returns #1 after accept edge
    task automatic send(input logic [3:0] o_op, input logic s,
                        input logic [31:0] xv, input logic [31:0] yv,
                        input logic [31:0] iv, input logic [32:0] e);
        int n;
        n = 0;
        op = o_op;
        swap = s;
        x = xv;
        y = yv;
        imm = iv;
        in_valid = 1'b1;
        if (g_rnd) out_ready = ($urandom_range(0, 3) != 0);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got in_ready 0 expected 1");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (g_rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x = $urandom;
        y = $urandom;
        imm = $urandom;
        op = 4'($urandom);
    endtask

    task automatic send_m(input logic [3:0] o_op, input logic s,
                          input logic [31:0] xv, input logic [31:0] yv,
                          input logic [31:0] iv);
        send(o_op, s, xv, yv, iv, model(o_op, s, xv, yv, iv));
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 || out_valid || busy) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got %0d pending expected 0",
                         exp_q.size());
                exp_q.delete();
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] rx;
        logic [31:0] ry;
        bit          bad;
        int          np;
        reset_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        op = 4'h0;
        swap = 1'b0;
        x = 32'h0;
        y = 32'h0;
        imm = 32'h0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_result", {32'h0, result}, 64'h0);
        chk("rst_err", {63'h0, err}, 64'h0);
        chk("rst_in_ready_rel", {63'h0, in_ready}, 64'h1);
        @(posedge clk);
        #1;

        send(4'h2, 1'b0, 32'd5, 32'd7, 32'd3, {1'b0, 32'h0000000F});
        chk("add_latency1", {63'h0, out_valid}, 64'h1);
        send(4'hB, 1'b1, 32'd10, 32'd4, 32'd3, {1'b0, 32'h0000000B});
        send(4'h6, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, {1'b0, 32'hFFFFFFFF});
        send(4'h8, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, {1'b0, 32'h0});
        send(4'h5, 1'b0, 32'h12345678, 32'd40, 32'd0, {1'b0, 32'h0});
        send(4'hD, 1'b0, 32'h80000000, 32'd31, 32'd0, {1'b0, 32'h1});
        send(4'h4, 1'b0, 32'd9, 32'd9, 32'd9, {1'b1, 32'h0});
        send(4'hF, 1'b0, 32'd9, 32'd9, 32'd9, {1'b1, 32'h0});
        send(4'h0, 1'b0, 32'd1, 32'd2, 32'd3, {1'b0, 32'h6});
        drain();

        send(4'h3, 1'b0, 32'h00010000, 32'h00010001, 32'd1,
             {1'b0, 32'h00010001});
        bad = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (!busy || in_ready || out_valid) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("mul_busy_window", {63'h0, bad}, 64'h0);
        chk("mul_valid_at_32", {63'h0, out_valid}, 64'h1);
        chk("mul_busy_done", {63'h0, busy}, 64'h0);
        drain();

        out_ready = 1'b0;
        send(4'h2, 1'b0, 32'd100, 32'd23, 32'd0, {1'b0, 32'd123});
        held = result;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (result !== 32'd123 || !out_valid || in_ready) bad = 1'b1;
        end
        chk("hold_stable", {63'h0, bad}, 64'h0);
        chk("hold_value", {32'h0, held}, 64'd123);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rx = $urandom;
            ry = $urandom;
            send_m(4'h2, 1'b0, rx, ry, 32'(k));
        end
        drain();
        bad = (pop_cyc.size() < 9);
        if (!bad) begin
            for (int i = pop_cyc.size() - 8; i < pop_cyc.size(); i++) begin
                if (pop_cyc[i] - pop_cyc[i-1] != 1) bad = 1'b1;
            end
        end
        chk("stream_back_to_back", {63'h0, bad}, 64'h0);

        send(4'h3, 1'b0, $urandom, $urandom, $urandom, {1'b0, 32'h0});
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("arst_busy", {63'h0, busy}, 64'h0);
        chk("arst_result", {32'h0, result}, 64'h0);
        chk("arst_in_ready", {63'h0, in_ready}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_in_ready_hold", {63'h0, in_ready}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_release_ready", {63'h0, in_ready}, 64'h1);

        send(4'h3, 1'b0, $urandom, $urandom, $urandom, {1'b0, 32'h0});
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        exp_q.delete();
        np = pop_cyc.size();
        @(negedge clk);
        chk("flush_in_ready", {63'h0, in_ready}, 64'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_out_valid", {63'h0, out_valid}, 64'h0);
        chk("flush_busy", {63'h0, busy}, 64'h0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_no_result", 64'(pop_cyc.size()), 64'(np));

        g_rnd = 1'b1;
        for (int n = 0; n < 250; n++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
            rx = $urandom;
            case ($urandom_range(0, 3))
                0: ry = 32'($urandom_range(0, 40));
                1: ry = rx;
                default: ry = $urandom;
            endcase
            send_m(rop, 1'($urandom), rx, ry, $urandom);
        end
        g_rnd = 1'b0;
        drain();
        chk("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
